// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier accumulator/control stage.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } mult_state_t;

    // Iteration counter width; one spare bit over $clog2 so BITS-1 always fits.
    function automatic int unsigned cnt_width(input int unsigned bits);
        return $clog2(bits) + 1;
    endfunction

endpackage

// File: rtl/mult_acc_control_if.sv
// Handshake and Q-register link for mult_acc_control.
// Optional MULT_DONE_HOLD_EN adds the ack input.
interface mult_acc_control_if #(
    parameter int unsigned BITS = 8
);
    logic            start;
    logic [BITS-1:0] M;
    logic            q0;
    logic            q_ls;
    logic            q_en;
    logic            q_d;
    logic [BITS-1:0] a_out;
    logic            busy;
    logic            done;
`ifdef MULT_DONE_HOLD_EN
    logic            ack;

    modport master (
        output start, M, q0, ack,
        input  q_ls, q_en, q_d, a_out, busy, done
    );

    modport slave (
        input  start, M, q0, ack,
        output q_ls, q_en, q_d, a_out, busy, done
    );
`else
    modport master (
        output start, M, q0,
        input  q_ls, q_en, q_d, a_out, busy, done
    );

    modport slave (
        input  start, M, q0,
        output q_ls, q_en, q_d, a_out, busy, done
    );
`endif
endinterface

// File: rtl/sumador_cout.sv
// BITS-wide unsigned adder; the extra MSB of sum is the carry-out.
module sumador_cout #(
    parameter int unsigned BITS = 8
) (
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    output logic [BITS:0]   sum
);

    // Zero-extend both operands so the carry lands in sum[BITS].
    always_comb begin
        sum = {1'b0, a} + {1'b0, b};
    end

endmodule

// File: rtl/mult_acc_control.sv
// Accumulator (A) and control stage of the sequential shift-add multiplier.
// Drives the external Q shift register and consumes its serial LSB (q0).
// Each RUN cycle adds M (when q0=1) and right-shifts {C,A,Q} in one step;
// the product is {a_out, Q}. Optional macro: MULT_DONE_HOLD_EN (done held
// until ack).
module mult_acc_control
    import mult_pkg::*;
#(
    parameter int unsigned BITS = 8
) (
    input logic               clk,
    input logic               rst,
    mult_acc_control_if.slave bus
);

    localparam int unsigned     CW   = cnt_width(BITS);
    localparam logic [CW-1:0]   LAST = CW'(BITS - 1);

    mult_state_t     state;
    logic [BITS-1:0] a_reg;
    logic [BITS-1:0] m_reg;
    logic [CW-1:0]   cnt;
    logic [BITS:0]   add_sum;
    logic [BITS:0]   sum;

    sumador_cout #(.BITS(BITS)) u_add (
        .a   (a_reg),
        .b   (m_reg),
        .sum (add_sum)
    );

    // Partial-product select; the carry C is sum[BITS], consumed the same
    // cycle as A's new MSB, so it never needs its own register.
    always_comb begin
        sum = bus.q0 ? add_sum : {1'b0, a_reg};
    end

    // State sequencing plus the A/M/counter datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_reg <= '0;
            m_reg <= '0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m_reg <= bus.M;
                        a_reg <= '0;
                        cnt   <= '0;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    state <= RUN;
                end
                RUN: begin
                    a_reg <= sum[BITS:1];
                    cnt   <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
`ifdef MULT_DONE_HOLD_EN
                    if (bus.ack) begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Moore-style control outputs; q_d alone follows q0 combinationally.
    always_comb begin
        bus.q_en = 1'b0;
        bus.q_ls = 1'b0;
        bus.q_d  = 1'b0;
        bus.busy = 1'b0;
        bus.done = 1'b0;
        case (state)
            LOAD: begin
                bus.q_en = 1'b1;
                bus.busy = 1'b1;
            end
            RUN: begin
                bus.q_en = 1'b1;
                bus.q_ls = 1'b1;
                bus.busy = 1'b1;
                bus.q_d  = sum[0];
            end
            DONE: begin
                bus.done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign bus.a_out = a_reg;

endmodule

// File: tb/tb_mult_acc_control.sv
// Self-checking bench for mult_acc_control with a behavioural Q register.
// Honours MULT_DONE_HOLD_EN when defined.
module tb_mult_acc_control;

    localparam int unsigned BITS = 8;

    logic            clk;
    logic            rst;
    logic [BITS-1:0] mult_dp;
    logic [BITS-1:0] q_reg;

    int checks = 0;
    int errors = 0;

    mult_acc_control_if #(.BITS(BITS)) bus ();

    mult_acc_control #(.BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Q register fixture: parallel load from mult_dp, or shift right taking q_d.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg <= '0;
        end else if (bus.q_en) begin
            if (!bus.q_ls) q_reg <= mult_dp;
            else           q_reg <= {bus.q_d, q_reg[BITS-1:1]};
        end
    end
    assign bus.q0 = q_reg[0];

    typedef struct {
        logic [7:0]  m;
        logic [7:0]  mul;
        logic [15:0] prod;
    } vec_t;

    vec_t vecs[6];

    // Reference model: plain integer product.
    function automatic logic [15:0] ref_prod(input logic [7:0] m, input logic [7:0] mul);
        return 16'(m) * 16'(mul);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (bus.done) begin
                seen = 1'b1;
                return;
            end
            tick();
        end
    endtask

    task automatic release_done();
`ifdef MULT_DONE_HOLD_EN
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
`else
        tick();
`endif
    endtask

    // One full multiplication; q_d in RUN cycle i must equal product bit i.
    task automatic run_mult(input logic [7:0] m, input logic [7:0] mul,
                            input logic [15:0] prod, input int restart_at,
                            input string tag);
        int lat;
        int i;
        bit seen;
        bit qd_ok;
        bus.M   = m;
        mult_dp = mul;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk($sformatf("%s_load_ctl", tag),
            32'({bus.busy, bus.q_en, bus.q_ls, bus.done}), 32'b1100);
        lat = 1; i = 0; seen = 1'b0; qd_ok = 1'b1;
        for (int c = 0; c < 40 && !seen; c++) begin
            tick();
            lat++;
            bus.start = 1'b0;
            if (bus.done) begin
                seen = 1'b1;
            end else if (bus.busy && bus.q_ls) begin
                if (i >= int'(BITS) || bus.q_d !== prod[i]) qd_ok = 1'b0;
                if (i == restart_at) bus.start = 1'b1;
                i++;
            end
        end
        bus.start = 1'b0;
        chk($sformatf("%s_latency", tag), seen ? 32'(lat) : 32'hFFFF, 32'(BITS + 2));
        chk($sformatf("%s_qd_bits", tag), 32'(qd_ok), 32'd1);
        chk($sformatf("%s_a_out", tag), 32'(bus.a_out), 32'(prod[15:8]));
        chk($sformatf("%s_q", tag), 32'(q_reg), 32'(prod[7:0]));
        release_done();
        chk($sformatf("%s_idle_after", tag), 32'({bus.done, bus.busy}), 32'd0);
    endtask

    initial begin
        bit seen;
        int held;
        logic [7:0] rm, rmul;

        rst = 1'b1;
        bus.start = 1'b0;
        bus.M = '0;
        mult_dp = '0;
`ifdef MULT_DONE_HOLD_EN
        bus.ack = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctl", 32'({bus.q_ls, bus.q_en, bus.q_d, bus.busy, bus.done}), 32'd0);
        chk("reset_a_out", 32'(bus.a_out), 32'd0);
        rst = 1'b0;
        tick();

        vecs[0] = '{8'd13,  8'd11,  16'd143};
        vecs[1] = '{8'd255, 8'd255, 16'd65025};
        vecs[2] = '{8'd0,   8'hA5,  16'd0};
        vecs[3] = '{8'hA5,  8'd0,   16'd0};
        vecs[4] = '{8'd1,   8'd1,   16'd1};
        vecs[5] = '{8'h80,  8'd2,   16'h0100};
        for (int v = 0; v < 6; v++) begin
            run_mult(vecs[v].m, vecs[v].mul, vecs[v].prod, -1, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 12; r++) begin
            rm   = 8'($urandom_range(0, 255));
            rmul = 8'($urandom_range(0, 255));
            run_mult(rm, rmul, ref_prod(rm, rmul), -1, $sformatf("rnd%0d", r));
        end

        // start re-pulsed during RUN cycle 3 must not disturb the operation.
        run_mult(8'd13, 8'd11, 16'd143, 3, "restart_ignored");

        // Asynchronous reset in RUN cycle 4 clears everything at once.
        bus.M = 8'd13;
        mult_dp = 8'd11;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        chk("pre_rst_running", 32'({bus.busy, bus.q_ls}), 32'b11);
        rst = 1'b1;
        #1;
        chk("mid_rst_ctl", 32'({bus.busy, bus.q_en, bus.done}), 32'd0);
        chk("mid_rst_a_out", 32'(bus.a_out), 32'd0);
        #2;
        rst = 1'b0;
        tick();
        run_mult(8'd7, 8'd9, 16'h003F, -1, "after_rst");

`ifdef MULT_DONE_HOLD_EN
        // done held with ack low; start ignored while in DONE.
        bus.M = 8'd13;
        mult_dp = 8'd11;
        bus.start = 1'b1;
        tick();
        wait_done(seen);
        chk("hold_done_seen", 32'(seen), 32'd1);
        held = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (bus.done && !bus.busy) held++;
        end
        chk("hold_done_5cyc", 32'(held), 32'd5);
        chk("hold_a_out", 32'(bus.a_out), 32'd0);
        chk("hold_q", 32'(q_reg), 32'h8F);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("hold_ack_idle", 32'({bus.done, bus.busy}), 32'd0);
        tick();
        bus.start = 1'b0;
        chk("hold_restart_load", 32'({bus.busy, bus.q_en, bus.q_ls}), 32'b110);
        wait_done(seen);
        chk("hold_second_done", 32'(seen), 32'd1);
        chk("hold_second_prod", 32'({bus.a_out, q_reg}), 32'd143);
        release_done();
`else
        // start held high: back-to-back operations with one IDLE cycle between.
        bus.M = 8'd3;
        mult_dp = 8'd5;
        bus.start = 1'b1;
        tick();
        wait_done(seen);
        chk("b2b_done_seen", 32'(seen), 32'd1);
        chk("b2b_prod1", 32'({bus.a_out, q_reg}), 32'd15);
        tick();
        chk("b2b_idle_gap", 32'({bus.done, bus.busy}), 32'd0);
        tick();
        bus.start = 1'b0;
        chk("b2b_second_load", 32'({bus.busy, bus.q_en, bus.q_ls}), 32'b110);
        wait_done(seen);
        chk("b2b_second_done", 32'(seen), 32'd1);
        chk("b2b_prod2", 32'({bus.a_out, q_reg}), 32'd15);
        tick();
        chk("b2b_done_pulse", 32'({bus.done, bus.busy}), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
